// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: queued-result entry layout and the
// register one-hot helper used to build the pending-register mask.
package wb_pkg;
  localparam int XLEN_DEFAULT = 64;
  localparam int REG_ADDR_W   = 5;

  // The payload is sized for the widest supported XLEN; narrower builds use the low bits.
  typedef struct packed {
    logic                    live;
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

  function automatic logic [31:0] onehot_rd(input logic [REG_ADDR_W-1:0] rd);
    onehot_rd = 32'd1 << rd;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of queued memory results. Entries can be killed in place by
// destination register so a younger ALU write supersedes them.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [REG_ADDR_W-1:0]             pushRd,
  input  logic [XLEN-1:0]                   pushData,
  input  logic                              pop,
  input  logic                              killEn,
  input  logic [REG_ADDR_W-1:0]             killRd,
  output logic                              full,
  output logic                              empty,
  output logic                              headLive,
  output logic [REG_ADDR_W-1:0]             headRd,
  output logic [XLEN-1:0]                   headData,
  output logic [DEPTH-1:0]                  liveVec,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]  rdVec
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign headLive = entries[rdPtr].live;
  assign headRd   = entries[rdPtr].rd;
  assign headData = XLEN'(entries[rdPtr].data);

  always_comb begin
    liveVec = '0;
    rdVec   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      liveVec[i] = entries[i].live;
      rdVec[i]   = entries[i].rd;
    end
  end

  // Kill first, then pop clears the head slot, then push claims the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (killEn && entries[i].live && (entries[i].rd == killRd))
          entries[i].live <= 1'b0;
      end
      if (pop) begin
        entries[rdPtr].live <= 1'b0;
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (push) begin
        entries[wrPtr] <= '{live: 1'b1, rd: pushRd, data: XLEN_DEFAULT'(pushData)};
        wrPtr <= wrPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Write-back stage: merges the single-cycle ALU path and the handshaked memory
// path into the register file's one write port, queueing memory results that lose.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeRegister,
  output logic [XLEN-1:0]       writeData,
  output logic [31:0]           pending_mask
);
  logic                             full;
  logic                             empty;
  logic                             headLive;
  logic [REG_ADDR_W-1:0]            headRd;
  logic [XLEN-1:0]                  headData;
  logic [DEPTH-1:0]                 liveVec;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rdVec;

  logic                  memFire;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  killEn;
  logic                  selWrite;
  logic [REG_ADDR_W-1:0] selRd;
  logic [XLEN-1:0]       selData;

  assign mem_ready = !full;
  assign memFire   = mem_valid && mem_ready;
  // ALU is always younger than anything queued, so it supersedes matching entries.
  assign killEn    = alu_valid && (alu_rd != '0);

  always_comb begin
    selWrite = 1'b0;
    selRd    = '0;
    selData  = '0;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (alu_valid) begin
      selWrite = (alu_rd != '0);
      selRd    = alu_rd;
      selData  = alu_data;
    end else if (!empty) begin
      pop      = 1'b1;
      selWrite = headLive && (headRd != '0);
      selRd    = headRd;
      selData  = headData;
    end else if (memFire) begin
      bypass   = 1'b1;
      selWrite = (mem_rd != '0);
      selRd    = mem_rd;
      selData  = mem_data;
    end
    // A same-cycle ALU write to the same register makes the memory result dead on arrival.
    push = memFire && !bypass && (mem_rd != '0) && !(alu_valid && (mem_rd == alu_rd));
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pushRd   (mem_rd),
    .pushData (mem_data),
    .pop      (pop),
    .killEn   (killEn),
    .killRd   (alu_rd),
    .full     (full),
    .empty    (empty),
    .headLive (headLive),
    .headRd   (headRd),
    .headData (headData),
    .liveVec  (liveVec),
    .rdVec    (rdVec)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (liveVec[i]) pending_mask = pending_mask | onehot_rd(rdVec[i]);
    end
  end

  // Write-port register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      regWrite      <= selWrite;
      writeRegister <= selRd;
      writeData     <= selData;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic            clk;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            regWrite;
  logic [4:0]      writeRegister;
  logic [XLEN-1:0] writeData;
  logic [31:0]     pending_mask;

  int nChecks = 0;
  int nFails  = 0;

  writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .pending_mask  (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds memory results waiting for the port, oldest first.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    bit          live;
  } mEnt_t;

  mEnt_t       mq[$];
  logic        expWr;
  logic [4:0]  expRd;
  logic [63:0] expData;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      expWr   = 1'b0;
      expRd   = '0;
      expData = '0;
    end else begin
      bit    ready;
      bit    fire;
      bit    taken;
      mEnt_t e;
      ready = (mq.size() < DEPTH);
      fire  = mem_valid && ready;
      taken = 1'b0;
      expWr = 1'b0;
      if (alu_valid) begin
        expWr   = (alu_rd != 0);
        expRd   = alu_rd;
        expData = alu_data;
        foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
        e       = mq.pop_front();
        expWr   = e.live;
        expRd   = e.rd;
        expData = e.data;
      end else if (fire) begin
        expWr   = (mem_rd != 0);
        expRd   = mem_rd;
        expData = mem_data;
        taken   = 1'b1;
      end
      if (fire && !taken && mem_rd != 0 && !(alu_valid && alu_rd == mem_rd)) begin
        e.rd = mem_rd; e.data = mem_data; e.live = 1'b1;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].live) m = m | (32'd1 << mq[i].rd);
    check("model_regWrite", regWrite, expWr);
    if (expWr || !rst_n) begin
      check("model_writeRegister", writeRegister, expRd);
      check("model_writeData", writeData, expData);
    end
    check("model_mem_ready", mem_ready, (mq.size() < DEPTH));
    check("model_pending_mask", pending_mask, m);
    check("no_x0_write", regWrite && (writeRegister == 0), 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  initial begin
    int acc;
    bit accNow;
    logic [4:0] got[$];

    rst_n = 1'b0;
    idle();
    alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;

    // Reset holds the port quiet even with ALU traffic present.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h11;
    repeat (2) tick();
    check("rst_regWrite", regWrite, 1'b0);
    check("rst_pending_mask", pending_mask, 32'h0);
    check("rst_mem_ready", mem_ready, 1'b1);
    check("rst_writeData", writeData, 64'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_regWrite", regWrite, 1'b1);
    check("post_rst_rd", writeRegister, 5'd5);
    check("post_rst_data", writeData, 64'h11);

    // Collision: ALU wins, memory queued behind it.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'hB;
    tick();
    idle();
    check("coll_wr1", regWrite, 1'b1);
    check("coll_rd1", writeRegister, 5'd3);
    check("coll_data1", writeData, 64'hA);
    check("coll_mask1", pending_mask, 32'h10);
    tick();
    check("coll_wr2", regWrite, 1'b1);
    check("coll_rd2", writeRegister, 5'd4);
    check("coll_data2", writeData, 64'hB);
    check("coll_mask2", pending_mask, 32'h0);
    tick();
    check("coll_idle", regWrite, 1'b0);

    // Full FIFO: ALU starves the queue for 6 cycles while memory offers x10..x14.
    acc = 0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'h77;
    mem_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      mem_rd = 5'(10 + acc); mem_data = 64'h100 + 64'(acc);
      accNow = mem_ready;
      tick();
      if (accNow) acc++;
    end
    check("full_accepts", 64'(acc), 64'd4);
    alu_valid = 1'b0;
    check("full_ready_low", mem_ready, 1'b0);
    for (int c = 0; c < 8; c++) begin
      accNow = mem_ready;
      tick();
      if (regWrite) got.push_back(writeRegister);
      if (accNow) mem_valid = 1'b0;
    end
    check("full_drain_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check("full_drain_order", got[i], 5'(10 + i));
    idle();

    // WAW kill: queued x7 superseded by a later ALU x7.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h9;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h1;
    tick();
    check("waw_mask_set", pending_mask, 32'h80);
    mem_valid = 1'b0;
    alu_rd = 5'd7; alu_data = 64'h2;
    tick();
    idle();
    check("waw_alu_wr", regWrite, 1'b1);
    check("waw_alu_rd", writeRegister, 5'd7);
    check("waw_alu_data", writeData, 64'h2);
    check("waw_mask_clear", pending_mask, 32'h0);
    tick();
    check("waw_killed_slot", regWrite, 1'b0);
    tick();
    check("waw_after", regWrite, 1'b0);

    // x0 from both sources is swallowed.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'hEE;
    tick();
    check("x0_both_wr", regWrite, 1'b0);
    check("x0_both_mask", pending_mask, 32'h0);
    alu_valid = 1'b0;
    tick();
    mem_valid = 1'b0;
    check("x0_bypass_wr", regWrite, 1'b0);
    tick();

    // Same-cycle same-rd: memory result discarded.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h5;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 64'h6;
    check("same_rd_ready", mem_ready, 1'b1);
    tick();
    idle();
    check("same_rd_wr", regWrite, 1'b1);
    check("same_rd_rd", writeRegister, 5'd9);
    check("same_rd_data", writeData, 64'h5);
    check("same_rd_mask", pending_mask, 32'h0);
    tick();
    check("same_rd_no_second", regWrite, 1'b0);

    // Randomized traffic, with ALU-heavy phases to fill the queue and one mid-run reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int aluPct;
      aluPct = ((cyc / 200) % 2 == 0) ? 30 : 85;
      alu_valid = ($urandom_range(99) < aluPct);
      alu_rd    = 5'($urandom_range(7));
      alu_data  = {$urandom, $urandom};
      mem_valid = ($urandom_range(99) < 60);
      mem_rd    = 5'($urandom_range(7));
      mem_data  = {$urandom, $urandom};
      if (cyc == 1500) rst_n = 1'b0;
      if (cyc == 1503) rst_n = 1'b1;
      tick();
    end
    idle();
    repeat (DEPTH + 3) tick();
    check("final_mask", pending_mask, 32'h0);
    check("final_idle", regWrite, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-back stage in front of the 32×64-bit register file. It merges two result sources into the file's single write port (`regWrite` / `writeRegister` / `writeData`):
- a single-cycle ALU path with no backpressure;
- a variable-latency memory/long-op path with a valid/ready handshake.

Memory results that lose arbitration wait in a small FIFO. A pending-register mask is exported so issue logic can stall on RAW hazards against queued writes.

## Interface
Parameters:
- `DEPTH`, default 4: memory-result FIFO entries (power of two, ≥2).
- `XLEN`, default 64: data width.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `alu_valid` input 1: ALU result present this cycle; always accepted.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input XLEN: ALU result.
- `mem_valid` input 1: memory result offered.
- `mem_ready` output 1: memory result accepted this cycle; equals `!full`, combinational.
- `mem_rd` input 5: memory destination register.
- `mem_data` input XLEN: memory result.
- `regWrite` output 1: register-file write enable, registered.
- `writeRegister` output 5: register-file write address, registered.
- `writeData` output XLEN: register-file write data, registered.
- `pending_mask` output 32: bit n set while a live FIFO entry targets xn, combinational from FIFO state.

## Operation
Each cycle, the registered write port is loaded by priority:
1. **`alu_valid`:** write the ALU result.
2. **Otherwise, FIFO non-empty:** pop the head and write it. A killed head pops with `regWrite`=0.
3. **Otherwise, memory handshake fires (`mem_valid && mem_ready`):** bypass straight to the port without touching the FIFO.
4. **Otherwise:** `regWrite`=0.

Enqueue rules:
- An accepted memory result that is not bypassed is pushed at the tail.
- Push and pop in the same cycle are legal. Count is unchanged, and a push is accepted when full only if a pop occurs that cycle. `mem_ready` still reports `!full`, so conservatively no push is taken while full.

Write-after-write ordering (ALU is always younger than any queued memory result):
- If `alu_valid` and `alu_rd` matches live FIFO entries, all matching entries are killed (valid bit cleared, slot kept) in the same cycle.
- If the memory handshake fires with `mem_rd == alu_rd` in the same cycle, the memory result is accepted and discarded (not enqueued).

x0 handling:
- `alu_rd`=0 or `mem_rd`=0: the result is accepted but never written.
- No x0 write ever reaches the port: `regWrite`=0 in that slot.
- An x0 memory result is not enqueued.

`pending_mask` is the OR of one-hot(rd) over live FIFO entries. It excludes the entry currently on the write port.

## Timing
- **Reset (`rst_n` low, async):** `regWrite`=0, `writeRegister`=0, `writeData`=0. FIFO empty and all entries dead, so `pending_mask`=0 and `mem_ready`=1.
- **Reset mid-operation:** queued writes are lost and nothing is written afterwards.
- **ALU latency:** exactly 1 cycle, input cycle to `regWrite` high.
- **Memory latency:** 1 cycle when bypassed. Otherwise 1 + (entries ahead) + (ALU cycles that pre-empt it).
- **Throughput:** one write per cycle. Sustained `alu_valid` starves the FIFO. This is intentional: upstream guarantees ALU bubbles.
- **Pointers:** `log2(DEPTH)` bits and wrap modulo DEPTH. The count is `log2(DEPTH)+1` bits; full when count==DEPTH, empty when count==0.
- **Kill timing:** a kill takes effect at the clock edge. A killed head popped in the next cycle produces no write.

## Structure
- **Package `wb_pkg`:**
  - `XLEN_DEFAULT`=64 and `REG_ADDR_W`=5.
  - Struct `wb_entry_t` {`live`, `rd[4:0]`, `data[XLEN-1:0]`}.
  - Function `onehot_rd` returning 32 bits.
- **Sub-module `wb_fifo`:**
  - DEPTH-entry circular buffer of `wb_entry_t` with push/pop/full/empty.
  - Per-entry kill by rd compare.
  - Live-entry rd vector for mask generation.
- **Top level:** arbitration, bypass, x0 filtering and output registers.

## Test plan
- **Reset:** hold `rst_n`=0 with `alu_valid`=1 → `regWrite`=0 and `pending_mask`=0. After release, the ALU write x5=0x11 appears 1 cycle later.
- **Collision:** `alu_valid` (x3=0xA) and `mem_valid` (x4=0xB) in the same cycle, then idle.
  - Cycle+1: write x3=0xA, with `pending_mask` bit 4 set in the collision cycle+1.
  - Cycle+2: write x4=0xB, and the mask clears.
- **Full FIFO:** hold `alu_valid` for 6 cycles while offering 5 memory results (x10..x14).
  - `mem_ready` drops after 4 acceptances.
  - When the ALU stops, x10..x13 drain in order, then x14 is accepted.
- **WAW kill:** queue memory x7=0x1. A later ALU x7=0x2 kills it. Final writes: x7=0x2 only, with the killed slot giving a `regWrite`=0 cycle, and bit 7 cleared.
- **x0:** ALU x0=0xFF and memory x0=0xEE → never `regWrite`=1 with `writeRegister`=0, and `pending_mask` stays 0.
- **Same-cycle same rd:** ALU x9=0x5 with memory x9=0x6 → `mem_ready`=1, single write x9=0x5, and nothing enqueued.
